// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, issues instruction-memory requests over a
// req/gnt/rvalid interface, buffers returned words in order and hands
// {instr, instr_pc, opcode} to decode with a valid/ready handshake. A redirect
// flushes the wrong path and refetches from the new target.
// Optional feature macro: IFU_MISALIGN_CHK_EN adds the misalign_err output and
// forces redirect targets to word alignment. Without it redirect_pc is used verbatim.
module instr_fetch_unit #(
  parameter int unsigned       PC_W      = 64,
  parameter int unsigned       INSTR_W   = 32,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 arst_n,
  output logic                 imem_req,
  output logic [PC_W-1:0]      imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [INSTR_W-1:0]   imem_rdata,
  input  logic                 redirect,
  input  logic [PC_W-1:0]      redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [INSTR_W-1:0]   instr,
  output logic [PC_W-1:0]      instr_pc,
  output logic [6:0]           opcode
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic                 misalign_err
`endif
);

  // Counters hold 0..BUF_DEPTH; pointers index a power-of-two ring and wrap freely.
  localparam int unsigned      CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam int unsigned      PTR_W   = $clog2(BUF_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] word;
    logic [PC_W-1:0]    pc;
  } ent_t;

  state_e             state_q;
  logic [PC_W-1:0]    fetch_pc_q;   // next address to request
  logic [PC_W-1:0]    resp_pc_q;    // PC of the next word that will be kept
  logic [CNT_W-1:0]   out_q;        // granted, not yet returned
  logic [CNT_W-1:0]   disc_q;       // returns still to be thrown away
  logic [CNT_W-1:0]   cnt_q;        // buffered entries
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  ent_t               buf_q [BUF_DEPTH];

  logic [PC_W-1:0]    tgt_pc;
  logic [CNT_W:0]     credit_used;
  logic [CNT_W-1:0]   out_nxt;
  logic [CNT_W-1:0]   disc_nxt;
  logic               gnt_fire;
  logic               rv_fire;
  logic               drop;
  logic               push;
  logic               pop;
  ent_t               head;

`ifdef IFU_MISALIGN_CHK_EN
  assign tgt_pc = {redirect_pc[PC_W-1:2], 2'b00};
`else
  assign tgt_pc = redirect_pc;
`endif

  // Every request in flight plus every buffered word reserves a buffer slot,
  // so a returning word always has somewhere to land.
  assign credit_used = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req    = (state_q == RUN) && !redirect && (credit_used < DEPTH_C);
  assign imem_addr   = fetch_pc_q;

  // gnt only counts while a request is actually up; since req is forced low in a
  // redirect cycle, a gnt seen then is not a grant. An rvalid with nothing
  // outstanding is a protocol error and is ignored.
  assign gnt_fire = imem_req & imem_gnt;
  assign rv_fire  = imem_rvalid & (out_q != '0);
  assign out_nxt  = out_q + CNT_W'(gnt_fire) - CNT_W'(rv_fire);

  // A return is dropped while old-path words are pending or when a redirect
  // lands in the same cycle; otherwise it is kept.
  assign drop     = rv_fire & ((disc_q != '0) | redirect);
  assign push     = rv_fire & ~drop;
  assign disc_nxt = disc_q - CNT_W'(rv_fire & (disc_q != '0));

  // Decode sees the buffer head directly; everything reads as zero when empty.
  assign head        = buf_q[rd_ptr_q];
  assign instr_valid = (cnt_q != '0);
  assign pop         = instr_valid & instr_ready;
  assign instr       = instr_valid ? head.word : '0;
  assign instr_pc    = instr_valid ? head.pc   : '0;
  assign opcode      = instr_valid ? head.word[6:0] : 7'd0;

  // Buffer storage: written only on a kept return, no reset needed.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= '{word: imem_rdata, pc: resp_pc_q};
  end

  // Control FSM, PCs, outstanding/discard counters and buffer occupancy.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else if (redirect) begin
      // Highest priority: restart both PCs, flush the buffer (a same-cycle pop
      // simply completes as the entry disappears) and mark everything still
      // in flight after this cycle as old-path.
      fetch_pc_q <= tgt_pc;
      resp_pc_q  <= tgt_pc;
      out_q      <= out_nxt;
      disc_q     <= out_nxt;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      state_q    <= (out_nxt != '0) ? FLUSH : RUN;
    end else begin
      if (gnt_fire) fetch_pc_q <= fetch_pc_q + PC_W'(4);
      if (push) begin
        resp_pc_q <= resp_pc_q + PC_W'(4);
        wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      out_q  <= out_nxt;
      disc_q <= disc_nxt;
      cnt_q  <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      case (state_q)
        BOOT:    state_q <= RUN;
        FLUSH:   if (disc_nxt == '0) state_q <= RUN;
        default: state_q <= state_q;
      endcase
    end
  end

`ifdef IFU_MISALIGN_CHK_EN
  // One-cycle flag the cycle after a redirect whose target was not word aligned.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) misalign_err <= 1'b0;
    else         misalign_err <= redirect & (redirect_pc[1:0] != 2'b00);
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a randomized in-order memory model drives the
// imem side, a driver issues ready/redirect stimulus, and a negedge monitor
// scores the delivered stream against the sequential-PC model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  localparam int unsigned     PC_W      = 64;
  localparam int unsigned     INSTR_W   = 32;
  localparam int unsigned     BUF_DEPTH = 2;
  localparam logic [63:0]     RST_PC    = 64'h0;

  logic               clk = 1'b0;
  logic               arst_n;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic [6:0]         opcode;
`ifdef IFU_MISALIGN_CHK_EN
  logic               misalign_err;
`endif

  instr_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .arst_n(arst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .opcode(opcode)
`ifdef IFU_MISALIGN_CHK_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h @%0t", name, act, exp, $time);
  endtask

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] word_of(input logic [63:0] pc);
    return (pc[31:0] * 32'h9E37_79B1) ^ pc[63:32] ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [63:0] tgt_of(input logic [63:0] p);
`ifdef IFU_MISALIGN_CHK_EN
    return p & ~64'h3;
`else
    return p;
`endif
  endfunction

  // ---------------- memory model: in-order, >=1 cycle latency ----------------
  logic [63:0] memq[$];
  int gnt_pct  = 100;
  int rv_pct   = 100;
  int gnt_wait = 0;
  bit spur_en  = 0;
  int wait_cnt = 0;

  initial begin
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        memq.delete(); wait_cnt = 0;
      end else begin
        if (imem_rvalid && memq.size() > 0) void'(memq.pop_front());
        if (imem_req && imem_gnt) begin memq.push_back(imem_addr); wait_cnt = 0; end
        else if (imem_req) wait_cnt++;
        else wait_cnt = 0;
      end
      @(posedge clk); #1;
      imem_gnt = (wait_cnt >= gnt_wait) && ($urandom_range(99) < gnt_pct);
      if (memq.size() > 0 && $urandom_range(99) < rv_pct) begin
        imem_rvalid = 1; imem_rdata = word_of(memq[0]);
      end else if (memq.size() == 0 && spur_en && $urandom_range(99) < 3) begin
        imem_rvalid = 1; imem_rdata = $urandom;
      end else begin
        imem_rvalid = 0; imem_rdata = $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  // Expected delivery is simply consecutive PCs from the latest restart point.
  logic [63:0] exp_q[$];
  logic [63:0] exp_tail, exp_fetch, last_pc;
  int inflight, stale, inf_n;
  int npop = 0;
  bit prev_stall, prev_mis, fire, rv;

  task automatic restart(input logic [63:0] t);
    exp_q.delete(); exp_fetch = t; exp_tail = t;
    for (int i = 0; i < 8; i++) begin exp_q.push_back(exp_tail); exp_tail += 4; end
  endtask

  always @(negedge clk) begin
    if (!arst_n) begin
      restart(RST_PC); inflight = 0; stale = 0; prev_stall = 0; prev_mis = 0;
    end else begin
      if (!instr_valid)
        chk(instr == '0 && instr_pc == '0 && opcode == '0, "idle_zero", instr_pc | 64'(instr) | 64'(opcode), 0);
      else
        chk(opcode == instr[6:0], "opcode", 64'(opcode), 64'(instr[6:0]));
      if (instr_valid && instr_ready) begin
        chk(instr_pc == exp_q[0], "instr_pc", instr_pc, exp_q[0]);
        chk(instr == word_of(exp_q[0]), "instr", 64'(instr), 64'(word_of(exp_q[0])));
        last_pc = instr_pc; npop++;
        void'(exp_q.pop_front()); exp_q.push_back(exp_tail); exp_tail += 4;
      end
      chk(!(imem_req && (redirect || stale > 0)), "req_gate", 64'(imem_req), 0);
      if (imem_req) chk(imem_addr == exp_fetch, "imem_addr", imem_addr, exp_fetch);
      if (prev_stall) chk(imem_req || redirect, "req_hold", 64'(imem_req), 1);
`ifdef IFU_MISALIGN_CHK_EN
      chk(misalign_err == prev_mis, "misalign_err", 64'(misalign_err), 64'(prev_mis));
      prev_mis = redirect && (redirect_pc[1:0] != 2'b00);
`endif
      fire  = imem_req && imem_gnt;
      rv    = imem_rvalid && inflight > 0;
      inf_n = inflight + int'(fire) - int'(rv);
      chk(inf_n <= BUF_DEPTH, "credit", 64'(inf_n), 64'(BUF_DEPTH));
      if (redirect) begin
        restart(tgt_of(redirect_pc)); stale = inf_n;
      end else begin
        if (fire) exp_fetch += 4;
        if (rv && stale > 0) stale--;
      end
      inflight   = inf_n;
      prev_stall = imem_req && !imem_gnt && !redirect;
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(); @(posedge clk); #2; endtask

  task automatic wait_pop(input string name, input logic [63:0] exp_pc);
    int base;
    bit got;
    base = npop; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin cyc(); got = (npop != base); end
    if (!got) chk(0, {name, "_timeout"}, 0, 1);
    else chk(last_pc == exp_pc, name, last_pc, exp_pc);
  endtask

  initial begin
    int base;
    bit found;
    logic [63:0] t;
    arst_n = 0; instr_ready = 1; redirect = 0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(!imem_req, "rst_req", 64'(imem_req), 0);
    chk(imem_addr == RST_PC, "rst_addr", imem_addr, RST_PC);
    chk(!instr_valid, "rst_valid", 64'(instr_valid), 0);
    chk(instr == '0 && instr_pc == '0 && opcode == '0, "rst_data", instr_pc, 0);
    @(posedge clk); #2; arst_n = 1;
    @(negedge clk);
    chk(!imem_req, "boot_no_req", 64'(imem_req), 0);

    // Streaming: every request granted, data one cycle later, decode always ready.
    base = npop;
    repeat (30) cyc();
    chk(npop - base >= 15, "stream_rate", 64'(npop - base), 15);

    // Decode stalls: requests stop once the credits are used up.
    instr_ready = 0;
    repeat (10) cyc();
    @(negedge clk);
    chk(!imem_req, "stall_req_drop", 64'(imem_req), 0);
    chk(instr_valid, "stall_valid", 64'(instr_valid), 1);
    cyc(); instr_ready = 1;
    repeat (20) cyc();

    // Slow grant: request held three cycles before each grant.
    gnt_wait = 3;
    repeat (40) cyc();
    gnt_wait = 0;

    // Redirect with two responses outstanding.
    rv_pct = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin cyc(); found = (memq.size() == 2); end
    chk(found, "setup_two_outstanding", 64'(memq.size()), 2);
    redirect = 1; redirect_pc = 64'h100;
    cyc(); redirect = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(!imem_req, "flush_no_req", 64'(imem_req), 0);
      chk(!instr_valid, "flush_empty", 64'(instr_valid), 0);
      cyc();
    end
    rv_pct = 100;
    wait_pop("redir_first_pc", 64'h100);

    // Redirect in the same cycle as a gnt and an rvalid.
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin cyc(); found = imem_req && imem_gnt && imem_rvalid; end
    chk(found, "setup_coincident", 0, 1);
    redirect = 1; redirect_pc = 64'h200;
    cyc(); redirect = 0;
    wait_pop("coincident_first_pc", 64'h200);

`ifdef IFU_MISALIGN_CHK_EN
    cyc(); redirect = 1; redirect_pc = 64'h102;
    cyc(); redirect = 0;
    @(negedge clk);
    chk(misalign_err, "misalign_pulse", 64'(misalign_err), 1);
    wait_pop("misalign_first_pc", 64'h100);
`endif

    // Randomized traffic, redirects, spurious rvalids and PC wraparound.
    spur_en = 1;
    base = npop;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        gnt_pct = $urandom_range(30, 100); rv_pct = $urandom_range(30, 100); gnt_wait = $urandom_range(0, 2);
      end
      cyc();
      instr_ready = ($urandom_range(99) < 70);
      redirect = ($urandom_range(15) == 0);
      if (redirect) begin
        if ($urandom_range(9) == 0) t = 64'hFFFF_FFFF_FFFF_FFF8;
        else t = {48'h0, 16'($urandom)} & ~64'h3;
`ifdef IFU_MISALIGN_CHK_EN
        if ($urandom_range(3) == 0) t[1:0] = 2'($urandom_range(1, 3));
`endif
        redirect_pc = t;
      end
    end
    chk(npop - base >= 200, "random_liveness", 64'(npop - base), 200);

    // Drain to a calm state.
    cyc(); redirect = 0; instr_ready = 1; spur_en = 0;
    gnt_pct = 100; rv_pct = 100; gnt_wait = 0;
    base = npop;
    repeat (40) cyc();
    chk(npop - base >= 10, "drain_liveness", 64'(npop - base), 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
